ps2_mouse_device_tx: RTL

//  Emulates the device side of a PS/2 mouse link: accepts a movement/button report,

---
 rtl/ps2_mouse_device_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_device_tx.sv
// ps2_mouse_device_tx
// Device side of a PS/2 mouse link. It accepts one movement/button report and packs it
// into a standard 3-byte stream packet. It then sends that packet while generating
// PS2_CLK itself, as a real mouse does. Both lines are open-collector: they are pulled
// low or left high-Z, never driven high.
// Ports:
//   CLOCK_50   system clock
//   reset      asynchronous, active-low reset
//   move_valid / move_ready   report handshake; move_ready is high only while idle
//   dx, dy     10-bit signed deltas, clamped to [-256,255] when packed
//   buttons    {middle, right, left}
//   PS2_CLK, PS2_DAT   open-collector PS/2 lines
//   busy       a packet is in flight, including retries
//   pkt_sent   one-cycle pulse after the stop bit of the last byte
module ps2_mouse_device_tx #(
  parameter int unsigned CLK_HALF = 2000,
  parameter int unsigned IDLE_CHK = 2500,
  parameter int unsigned BYTE_GAP = 2500
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [9:0] dx,
  input  logic [9:0] dy,
  input  logic [2:0] buttons,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       pkt_sent
);

  localparam int unsigned MaxA   = (CLK_HALF > IDLE_CHK) ? CLK_HALF : IDLE_CHK;
  localparam int unsigned MaxCnt = (MaxA > BYTE_GAP) ? MaxA : BYTE_GAP;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] HalfEnd  = CntW'(CLK_HALF - 1);
  localparam logic [CntW-1:0] QuartEnd = CntW'(CLK_HALF / 2 - 1);
  localparam logic [CntW-1:0] ChkEnd   = CntW'(IDLE_CHK - 1);
  localparam logic [CntW-1:0] GapEnd   = CntW'(BYTE_GAP - 1);
  // The synchronizer still shows our own low clock for two cycles after we release it.
  localparam logic [CntW-1:0] Blank    = CntW'(2);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StChk     = 3'd1;
  localparam logic [2:0] StSetup   = 3'd2;
  localparam logic [2:0] StLow     = 3'd3;
  localparam logic [2:0] StHigh    = 3'd4;
  localparam logic [2:0] StGap     = 3'd5;
  localparam logic [2:0] StInhibit = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [23:0]     pkt_q, pkt_d;
  logic            lo_q, lo_d;
  logic            sent_q, sent_d;
  logic            clk_meta_q, clk_sync_q;

  logic [8:0]  x_sat, y_sat;
  logic        x_ovf, y_ovf;
  logic [7:0]  cur_byte;
  logic [10:0] frame;
  logic        tx_bit, chk_en, inhibit;
  logic        clk_low, dat_low;
  logic [CntW-1:0] cnt_inc;

  // Clamp: a 10-bit value fits in 9 signed bits iff its top two bits agree.
  always_comb begin
    x_ovf = dx[9] ^ dx[8];
    y_ovf = dy[9] ^ dy[8];
    x_sat = x_ovf ? (dx[9] ? 9'h100 : 9'h0ff) : dx[8:0];
    y_sat = y_ovf ? (dy[9] ? 9'h100 : 9'h0ff) : dy[8:0];
  end

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = pkt_q[7:0];
      2'd1:    cur_byte = pkt_q[15:8];
      default: cur_byte = pkt_q[23:16];
    endcase
    frame  = {1'b1, ~^cur_byte, cur_byte, 1'b0};
    tx_bit = frame[bit_q];
  end

  // Host inhibit is only honoured while our clock is released and the byte is unfinished.
  always_comb begin
    chk_en  = (bit_q != 4'd10) &&
              ((state_q == StSetup) || ((state_q == StHigh) && (cnt_q >= Blank)));
    lo_d    = chk_en && !clk_sync_q;
    inhibit = lo_d && lo_q;
    cnt_inc = cnt_q + CntW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pkt_d   = pkt_q;
    sent_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (move_valid && move_ready) begin
          pkt_d   = {y_sat[7:0], x_sat[7:0], y_ovf, x_ovf, y_sat[8], x_sat[8], 1'b1, buttons};
          state_d = StChk;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      StChk: begin
        if (!clk_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == ChkEnd) begin
          state_d = StSetup;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSetup: begin
        if (inhibit) begin
          state_d = StInhibit;
        end else if (cnt_q == QuartEnd) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StLow: begin
        if (cnt_q == HalfEnd) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHigh: begin
        if (inhibit) begin
          state_d = StInhibit;
        end else if (cnt_q == QuartEnd) begin
          cnt_d = '0;
          if (bit_q == 4'd10) begin
            if (byte_q == 2'd2) begin
              state_d = StIdle;
              sent_d  = 1'b1;
            end else begin
              state_d = StGap;
              byte_d  = byte_q + 2'd1;
            end
          end else begin
            state_d = StSetup;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGap: begin
        if (cnt_q == GapEnd) begin
          state_d = StChk;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StInhibit: begin
        // Retry restarts the whole packet from byte 0 with the latched data.
        state_d = StChk;
        cnt_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      pkt_q      <= '0;
      lo_q       <= 1'b0;
      sent_q     <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      pkt_q      <= pkt_d;
      lo_q       <= lo_d;
      sent_q     <= sent_d;
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
    end
  end

  // Lines decode straight from state so an asynchronous reset releases them at once.
  always_comb begin
    clk_low    = (state_q == StLow);
    dat_low    = ((state_q == StSetup) || (state_q == StLow) || (state_q == StHigh)) && !tx_bit;
    busy       = (state_q != StIdle);
    move_ready = (state_q == StIdle) && !sent_q;
    pkt_sent   = sent_q;
  end

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule
